// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I-subset control sequencer: steps FETCH/DECODE/EXECUTE/MEM/WB,
// drives datapath selects and write enables, stalls on mem_ready, traps on unknown opcodes.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct75,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALU_control,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;

  logic       pc_write_c;
  logic       mem_write_c;
  logic       ir_write_c;
  logic       reg_write_c;
  logic [1:0] alu_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    pc_write_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    alu_op      = ALUOP_ADD;

    unique case (state_q)
      S_FETCH: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut captures OldPC + imm so a following BEQ already has its target
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        // strobe stays high for the whole stall so slow memory sees a stable request
        AdrSrc      = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        alu_op     = ALUOP_SUB;
        pc_write_c = zero;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_comb begin
    ALU_control = ALU_ADD;
    unique case (alu_op)
      ALUOP_ADD: ALU_control = ALU_ADD;
      ALUOP_SUB: ALU_control = ALU_SUB;
      default: begin
        unique case (funct3)
          3'b000:  ALU_control = (opcode[5] && funct75) ? ALU_SUB : ALU_ADD;
          3'b010:  ALU_control = ALU_SLT;
          3'b110:  ALU_control = ALU_OR;
          3'b111:  ALU_control = ALU_AND;
          default: ALU_control = ALU_ADD;
        endcase
      end
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    unique case (opcode)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Write enables are masked by rst_n so nothing commits while reset is held.
  assign PCWrite  = pc_write_c  & rst_n;
  assign MemWrite = mem_write_c & rst_n;
  assign IRWrite  = ir_write_c  & rst_n;
  assign RegWrite = reg_write_c & rst_n;
  assign illegal  = illegal_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized instruction stream against a trace-level reference model of the sequencer.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct75;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALU_control;
  logic [3:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b0110111;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct75(funct75),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALU_control(ALU_control),
    .illegal(illegal), .state_o(state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected ALU operation for an ALU instruction, by mnemonic meaning of funct3.
  function automatic logic [2:0] alu_of(logic [6:0] op, logic [2:0] f3, logic f75);
    if (f3 == 3'b000) return (op == OP_R && f75) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  // Packed {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,RegWrite,ALU_control}
  function automatic logic [15:0] exp_ctrl(int st, logic rdy, logic z, logic [6:0] op,
                                           logic [2:0] f3, logic f75);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0, imm;
    logic [2:0] alu = 3'b000;
    case (st)
      0:  begin sb = 2; rs = 2; irw = rdy; pcw = rdy; end
      1:  begin sa = 1; sb = 1; end
      2:  begin sa = 2; sb = 1; end
      3:  adr = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2; sb = 0; alu = alu_of(op, f3, f75); end
      7:  rw = 1;
      8:  begin sa = 2; sb = 1; alu = alu_of(op, f3, f75); end
      9:  begin sa = 1; sb = 2; pcw = 1; end
      10: begin sa = 2; alu = 3'b001; pcw = z; end
      default: ;
    endcase
    imm = (op == OP_SW) ? 2'd1 : (op == OP_BEQ) ? 2'd2 : (op == OP_JAL) ? 2'd3 : 2'd0;
    return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, alu};
  endfunction

  function automatic logic [15:0] got_ctrl();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
            RegWrite, ALU_control};
  endfunction

  // One cycle: apply mem_ready, compare against the model, advance to the next negedge.
  task automatic step(input int st, input logic rdy, input logic exp_ill);
    mem_ready = rdy;
    #1;
    check("state", state_o, st);
    check("ctrl", got_ctrl(), exp_ctrl(st, rdy, zero, opcode, funct3, funct75));
    check("illegal", illegal, exp_ill);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_instr(input int txn, input int kind, input int fst, input int mst);
    int   sq[$];
    logic rq[$];
    string name;
    logic [6:0] op;
    case (kind)
      0: begin op = OP_LW;  name = "lw";  end
      1: begin op = OP_SW;  name = "sw";  end
      2: begin op = OP_R;   name = "R";   end
      3: begin op = OP_I;   name = "I";   end
      4: begin op = OP_JAL; name = "jal"; end
      default: begin op = OP_BEQ; name = "beq"; end
    endcase
    opcode  = op;
    funct3  = 3'($urandom_range(0, 7));
    funct75 = 1'($urandom_range(0, 1));
    zero    = 1'($urandom_range(0, 1));
    for (int i = 0; i < fst; i++) begin sq.push_back(0); rq.push_back(1'b0); end
    sq.push_back(0); rq.push_back(1'b1);
    sq.push_back(1); rq.push_back(1'($urandom_range(0, 1)));
    case (kind)
      0, 1: begin
        int ms = (kind == 0) ? 3 : 5;
        sq.push_back(2); rq.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mst; i++) begin sq.push_back(ms); rq.push_back(1'b0); end
        sq.push_back(ms); rq.push_back(1'b1);
        if (kind == 0) begin sq.push_back(4); rq.push_back(1'($urandom_range(0, 1))); end
      end
      2, 3, 4: begin
        sq.push_back(kind == 2 ? 6 : kind == 3 ? 8 : 9);
        rq.push_back(1'($urandom_range(0, 1)));
        sq.push_back(7); rq.push_back(1'($urandom_range(0, 1)));
      end
      default: begin sq.push_back(10); rq.push_back(1'($urandom_range(0, 1))); end
    endcase
    for (int i = 0; i < sq.size(); i++) step(sq[i], rq[i], 1'b0);
    $display("[TB] txn %0d %s f3=%b f75=%b zero=%b fetch_stall=%0d mem_stall=%0d cycles=%0d",
             txn, name, funct3, funct75, zero, fst, (kind < 2) ? mst : 0, sq.size());
  endtask

  initial begin
    rst_n = 1'b0; opcode = OP_LW; funct3 = 0; funct75 = 0; zero = 0; mem_ready = 1'b1;
    @(negedge clk);
    #1;
    check("rst_state", state_o, 0);
    check("rst_ctrl", got_ctrl(), exp_ctrl(0, 1'b0, zero, opcode, funct3, funct75));
    check("rst_illegal", illegal, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corners first, then a random stream.
    run_instr(0, 0, 0, 0);
    run_instr(1, 1, 0, 2);
    opcode = OP_R;
    run_instr(2, 2, 0, 0);
    run_instr(3, 5, 0, 0);
    run_instr(4, 4, 0, 0);
    for (int t = 5; t < 45; t++)
      run_instr(t, int'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)));
    step(0, 1'b0, 1'b0);

    opcode = OP_BAD; funct3 = 0; funct75 = 0; zero = 0;
    step(0, 1'b1, 1'b0);
    step(1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(11, 1'($urandom_range(0, 1)), 1'b1);
    $display("[TB] txn trap opcode=%b held 4 cycles", opcode);

    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    check("trap_rst_state", state_o, 0);
    check("trap_rst_illegal", illegal, 1'b0);
    check("trap_rst_ctrl", got_ctrl(), exp_ctrl(0, 1'b0, zero, opcode, funct3, funct75));
    @(negedge clk);
    rst_n = 1'b1;

    opcode = OP_LW;
    step(0, 1'b1, 1'b0);
    step(1, 1'b1, 1'b0);
    step(2, 1'b1, 1'b0);
    mem_ready = 1'b0;
    #1;
    check("memread_state", state_o, 3);
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    check("abort_state", state_o, 0);
    check("abort_regwrite", RegWrite, 1'b0);
    check("abort_ctrl", got_ctrl(), exp_ctrl(0, 1'b0, zero, opcode, funct3, funct75));
    @(posedge clk);
    #1;
    check("abort_hold_state", state_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] txn lw aborted by reset in MEMREAD");
    run_instr(99, 0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
